// File: rtl/iob_acc_ctrl.sv
// Window controller for an external iob_acc: feeds len samples per window,
// captures the accumulated sum, presents it on valid/ready and clears the accumulator.
module iob_acc_ctrl #(
  parameter int unsigned DATA_W = 21,
  parameter int unsigned LEN_W  = 8
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              arst_n_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              acc_rst_o,
  output logic              acc_en_o,
  output logic [DATA_W-1:0] acc_incr_o,
  input  logic [DATA_W-1:0] acc_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o
);

  typedef enum logic [1:0] {
    CLR  = 2'd0,
    ACC  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   len_eff;
  logic [DATA_W-1:0]  out_data_d;
  logic               out_valid_d;

  // A zero-length request is treated as a single-sample window
  assign len_eff    = (len_i == '0) ? LEN_W'(1) : len_i;
  assign acc_incr_o = in_data_i;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q     <= CLR;
      cnt_q       <= '0;
      len_q       <= LEN_W'(1);
      out_data_o  <= '0;
      out_valid_o <= 1'b0;
    end else if (cke_i) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      out_data_o  <= out_data_d;
      out_valid_o <= out_valid_d;
    end
  end

  // Strobes toward the accumulator and upstream are gated by cke_i so a frozen
  // cycle never moves data even though the accumulator sees them combinationally.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    out_data_d  = out_data_o;
    out_valid_d = out_valid_o;
    in_ready_o  = 1'b0;
    acc_rst_o   = 1'b0;
    acc_en_o    = 1'b0;
    case (state_q)
      CLR: begin
        acc_rst_o = cke_i;
        acc_en_o  = cke_i;
        len_d     = len_eff;
        cnt_d     = '0;
        state_d   = ACC;
      end
      ACC: begin
        in_ready_o = cke_i;
        acc_en_o   = cke_i & in_valid_i;
        if (in_valid_i) begin
          if (cnt_q == len_q - LEN_W'(1)) begin
            state_d = WAIT;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end
      WAIT: begin
        // Final sum has settled in the accumulator; capture it and clear behind it
        out_data_d  = acc_data_i;
        out_valid_d = 1'b1;
        acc_rst_o   = cke_i;
        acc_en_o    = cke_i;
        len_d       = len_eff;
        cnt_d       = '0;
        state_d     = OUT;
      end
      OUT: begin
        if (out_valid_o && out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = ACC;
        end
      end
      default: state_d = CLR;
    endcase
  end

endmodule
